// File: rtl/xm23_dev_pkg.sv
// Shared XM-23 device definitions.
// Holds the standard device CSR bit positions (reused by the timer and later
// devices) and the serial transmitter FSM state encoding.
package xm23_dev_pkg;

  // Standard XM-23 device CSR layout
  localparam int unsigned CSR_IE  = 0;  // interrupt enable
  localparam int unsigned CSR_IO  = 1;  // direction: 0 = output device
  localparam int unsigned CSR_DBA = 2;  // data buffer available
  localparam int unsigned CSR_OF  = 3;  // overflow
  localparam int unsigned CSR_ENA = 4;  // device enable

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_dev_if.sv
// CPU-side bus of the XM-23 UART transmitter device.
//   csr_wr_en/csr_wr_data : CSR write strobe and value
//   dr_wr_en/dr_wr_data   : data register write strobe and byte to send
//   csr_out               : current CSR value
//   irq                   : interrupt request (level)
//   tx                    : serial line, idles high
// master = CPU side, slave = device side.
interface uart_tx_dev_if;
  logic       csr_wr_en;
  logic [7:0] csr_wr_data;
  logic       dr_wr_en;
  logic [7:0] dr_wr_data;
  logic [7:0] csr_out;
  logic       irq;
  logic       tx;

  modport master (
    output csr_wr_en, csr_wr_data, dr_wr_en, dr_wr_data,
    input  csr_out, irq, tx
  );

  modport slave (
    input  csr_wr_en, csr_wr_data, dr_wr_en, dr_wr_data,
    output csr_out, irq, tx
  );
endinterface

// File: rtl/uart_tx_dev_baud_tick.sv
// Baud-rate tick generator.
// Counts 0..CLKS_PER_BIT-1 and raises tick_o during the last count, so one
// tick appears every CLKS_PER_BIT cycles. clr_i forces the count back to 0.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous counter clear
//   tick_o : one-cycle tick at the end of each bit period
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_dev.sv
// XM-23 output device: 8N1 UART transmitter, LSB first.
// A DR write while enabled and DBA=1 starts a frame; DBA (and irq when IE is
// set) signal readiness for the next byte. A DR write while busy is dropped
// and sets OF. Clearing ENA aborts a frame in progress.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : CSR/DR write strobes, csr_out, irq, tx
module uart_tx_dev
  import xm23_dev_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx_dev_if.slave  bus
);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       ie_q, ie_d;
  logic       ena_q, ena_d;
  logic       of_q, of_d;
  logic       dba_q, dba_d;
  logic       irq_q, irq_d;
  logic       tx_q, tx_d;

  logic       tick;
  logic       baud_clr;
  logic       dr_accept;
  logic       dr_reject;
  logic       abort;
  logic [7:0] csr;
  logic       csr_unused;

  // Read-only / reserved CSR bits are ignored on write
  assign csr_unused = ^{bus.csr_wr_data[7:5], bus.csr_wr_data[2:1]};

  // DR decisions use the registered CSR, before any same-cycle CSR write
  assign dr_accept = bus.dr_wr_en & ena_q &  dba_q;
  assign dr_reject = bus.dr_wr_en & ena_q & ~dba_q;
  // ENA low while a frame is running: abort on the edge after ENA dropped
  assign abort     = ~ena_q & (state_q != ST_IDLE);

  // Counter restarts on every state entry and is held at 0 while idle
  assign baud_clr  = (state_d != state_q) | (state_q == ST_IDLE);

  baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (baud_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    ie_d    = ie_q;
    ena_d   = ena_q;
    of_d    = of_q;
    dba_d   = dba_q;
    irq_d   = ie_q & dba_q & ena_q;
    tx_d    = 1'b1;

    if (bus.csr_wr_en) begin
      ie_d  = bus.csr_wr_data[CSR_IE];
      ena_d = bus.csr_wr_data[CSR_ENA];
      of_d  = of_q & bus.csr_wr_data[CSR_OF];
    end
    // A rejected byte sets OF even if software clears OF in the same cycle
    if (dr_reject) begin
      of_d = 1'b1;
    end

    if (abort) begin
      state_d = ST_IDLE;
      bit_d   = '0;
      dba_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (dr_accept) begin
            shift_d = bus.dr_wr_data;
            dba_d   = 1'b0;
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (tick) state_d = ST_DATA;
        end
        ST_DATA: begin
          if (tick) begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            state_d = ST_IDLE;
            dba_d   = 1'b1;
          end
        end
      endcase
    end

    // tx is registered from the next state so it changes with the state
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      ie_q    <= 1'b0;
      ena_q   <= 1'b0;
      of_q    <= 1'b0;
      dba_q   <= 1'b1;
      irq_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      ie_q    <= ie_d;
      ena_q   <= ena_d;
      of_q    <= of_d;
      dba_q   <= dba_d;
      irq_q   <= irq_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    csr          = '0;
    csr[CSR_IE]  = ie_q;
    csr[CSR_IO]  = 1'b0;
    csr[CSR_DBA] = dba_q;
    csr[CSR_OF]  = of_q;
    csr[CSR_ENA] = ena_q;
  end

  assign bus.csr_out = csr;
  assign bus.irq     = irq_q;
  assign bus.tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev with CLKS_PER_BIT=4.
// A reference model tracks the CSR fields and the expected tx waveform as a
// queue of per-cycle line levels; it is compared every cycle. Directed table
// vectors and hand sequences cover the register rules and frame corner cases.
module tb_uart_tx_dev;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  logic clock = 1'b0;
  logic reset;

  uart_tx_dev_if bus ();

  uart_tx_dev #(
    .CLKS_PER_BIT (C),
    .CNT_W        (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic m_ie, m_ena, m_of, m_dba, m_irq, m_tx;
  logic m_wave[$];
  logic m_valid = 1'b0;
  logic chk_en  = 1'b0;

  always @(posedge clock) begin : model_p
    logic o_ie, o_ena, o_of, o_dba;
    logic [7:0] d;
    if (reset) begin
      m_ie = 1'b0; m_ena = 1'b0; m_of = 1'b0; m_dba = 1'b1;
      m_irq = 1'b0; m_tx = 1'b1;
      m_wave.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      o_ie = m_ie; o_ena = m_ena; o_of = m_of; o_dba = m_dba;
      m_irq = o_ie & o_dba & o_ena;
      if (bus.csr_wr_en) begin
        m_ie  = bus.csr_wr_data[0];
        m_ena = bus.csr_wr_data[4];
        m_of  = o_of & bus.csr_wr_data[3];
      end
      if (!o_ena && !o_dba) begin
        m_wave.delete();
        m_dba = 1'b1;
      end else if (!o_dba && m_wave.size() == 0) begin
        m_dba = 1'b1;
      end
      if (bus.dr_wr_en && o_ena) begin
        if (o_dba) begin
          d = bus.dr_wr_data;
          for (int i = 0; i < FRAME; i++) begin
            if (i < C)           m_wave.push_back(1'b0);
            else if (i >= 9 * C) m_wave.push_back(1'b1);
            else                 m_wave.push_back(d[3'((i - C) / C)]);
          end
          m_dba = 1'b0;
        end else begin
          m_of = 1'b1;
        end
      end
      m_tx = (m_wave.size() > 0) ? m_wave.pop_front() : 1'b1;
    end
  end

  always @(negedge clock) begin
    if (chk_en && errors < 30) begin
      checks++;
      if (bus.csr_out !== {3'b000, m_ena, m_of, m_dba, 1'b0, m_ie} ||
          bus.tx !== m_tx || bus.irq !== m_irq) begin
        errors++;
        $display("FAIL model t=%0t csr=%h exp %h tx=%b exp %b irq=%b exp %b",
                 $time, bus.csr_out, {3'b000, m_ena, m_of, m_dba, 1'b0, m_ie},
                 bus.tx, m_tx, bus.irq, m_irq);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic csr_write(input logic [7:0] d);
    bus.csr_wr_en = 1'b1; bus.csr_wr_data = d;
    tick();
    bus.csr_wr_en = 1'b0;
  endtask

  task automatic dr_write(input logic [7:0] d);
    bus.dr_wr_en = 1'b1; bus.dr_wr_data = d;
    tick();
    bus.dr_wr_en = 1'b0;
  endtask

  function automatic logic [FRAME-1:0] wave_of(input logic [7:0] b);
    logic [FRAME-1:0] w;
    for (int i = 0; i < FRAME; i++) begin
      if (i < C)          w[i] = 1'b0;
      else if (i < 9 * C) w[i] = b[3'((i - C) / C)];
      else                w[i] = 1'b1;
    end
    return w;
  endfunction

  // Samples tx for one frame time starting right after the accepting edge;
  // optionally issues a DR write after sample 'inj'.
  task automatic capture(input int inj, input logic [7:0] inj_d,
                         output logic [FRAME-1:0] w, output logic dba_last,
                         output logic [7:0] csr_inj);
    csr_inj  = '0;
    dba_last = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      w[i] = bus.tx;
      if (i == FRAME - 1) dba_last = bus.csr_out[2];
      if (i == inj) begin bus.dr_wr_en = 1'b1; bus.dr_wr_data = inj_d; end
      tick();
      if (i == inj) begin bus.dr_wr_en = 1'b0; csr_inj = bus.csr_out; end
    end
  endtask

  typedef struct {
    logic       csr_en;
    logic [7:0] csr_d;
    logic       dr_en;
    logic [7:0] dr_d;
    logic [7:0] exp_csr;
  } vec_t;

  vec_t tbl[14];

  initial begin : timeout_p
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main_p
    logic [FRAME-1:0] w;
    logic dba_last;
    logic [7:0] csr_inj;
    logic [7:0] d;
    int lows;

    tbl[0]  = '{1'b1, 8'h01, 1'b0, 8'h00, 8'h05};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 8'h55, 8'h05};
    tbl[2]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h15};
    tbl[3]  = '{1'b1, 8'h08, 1'b0, 8'h00, 8'h04};
    tbl[4]  = '{1'b1, 8'hE0, 1'b0, 8'h00, 8'h04};
    tbl[5]  = '{1'b1, 8'h10, 1'b0, 8'h00, 8'h14};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h81, 8'h10};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'h42, 8'h18};
    tbl[8]  = '{1'b1, 8'h18, 1'b0, 8'h00, 8'h18};
    tbl[9]  = '{1'b1, 8'h1A, 1'b0, 8'h00, 8'h18};
    tbl[10] = '{1'b1, 8'h11, 1'b0, 8'h00, 8'h11};
    tbl[11] = '{1'b1, 8'h19, 1'b1, 8'h00, 8'h19};
    tbl[12] = '{1'b1, 8'h01, 1'b0, 8'h00, 8'h01};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h05};

    bus.csr_wr_en = 1'b0; bus.csr_wr_data = '0;
    bus.dr_wr_en  = 1'b0; bus.dr_wr_data  = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset values and idle
    check("reset_csr", 64'(bus.csr_out), 64'h04);
    check("reset_tx",  64'(bus.tx), 64'h1);
    check("reset_irq", 64'(bus.irq), 64'h0);
    lows = 0;
    repeat (50) begin tick(); if (bus.tx !== 1'b1 || bus.irq !== 1'b0) lows++; end
    check("idle_quiet", 64'(lows), 64'h0);
    check("idle_csr", 64'(bus.csr_out), 64'h04);

    // Basic frame 8'hA5
    csr_write(8'h11);
    dr_write(8'hA5);
    capture(-1, 8'h00, w, dba_last, csr_inj);
    check("a5_wave", 64'(w), 64'(wave_of(8'hA5)));
    check("a5_dba_last_cycle", 64'(dba_last), 64'h0);
    check("a5_dba_after", 64'(bus.csr_out), 64'h15);
    check("a5_irq_before", 64'(bus.irq), 64'h0);
    tick();
    check("a5_irq_after", 64'(bus.irq), 64'h1);

    // Register rule table
    do_reset();
    foreach (tbl[i]) begin
      bus.csr_wr_en = tbl[i].csr_en; bus.csr_wr_data = tbl[i].csr_d;
      bus.dr_wr_en  = tbl[i].dr_en;  bus.dr_wr_data  = tbl[i].dr_d;
      tick();
      bus.csr_wr_en = 1'b0; bus.dr_wr_en = 1'b0;
      check($sformatf("table_%0d", i), 64'(bus.csr_out), 64'(tbl[i].exp_csr));
    end
    repeat (FRAME) tick();

    // Overrun: second byte 10 cycles into a frame
    do_reset();
    csr_write(8'h10);
    dr_write(8'hC3);
    capture(9, 8'h3C, w, dba_last, csr_inj);
    check("of_mid_csr", 64'(csr_inj), 64'h18);
    check("of_wave", 64'(w), 64'(wave_of(8'hC3)));
    check("of_after_csr", 64'(bus.csr_out), 64'h1C);
    lows = 0;
    repeat (FRAME) begin tick(); if (bus.tx !== 1'b1) lows++; end
    check("of_no_second", 64'(lows), 64'h0);
    csr_write(8'h11);
    check("of_clear", 64'(bus.csr_out), 64'h15);

    // DR write with ENA=0
    do_reset();
    dr_write(8'h55);
    check("dis_csr", 64'(bus.csr_out), 64'h04);
    lows = 0;
    repeat (FRAME + 10) begin tick(); if (bus.tx !== 1'b1) lows++; end
    check("dis_no_tx", 64'(lows), 64'h0);

    // Abort by clearing ENA at cycle 15 of a frame
    csr_write(8'h11);
    dr_write(8'h00);
    repeat (14) tick();
    csr_write(8'h01);
    tick();
    check("abort_tx", 64'(bus.tx), 64'h1);
    check("abort_csr", 64'(bus.csr_out), 64'h05);
    csr_write(8'h11);
    dr_write(8'hFF);
    capture(-1, 8'h00, w, dba_last, csr_inj);
    check("abort_next_wave", 64'(w), 64'(wave_of(8'hFF)));

    // Reset in the DATA phase
    dr_write(8'h00);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_tx", 64'(bus.tx), 64'h1);
    check("rst_mid_csr", 64'(bus.csr_out), 64'h04);
    csr_write(8'h11);
    dr_write(8'h5A);
    capture(-1, 8'h00, w, dba_last, csr_inj);
    check("rst_next_wave", 64'(w), 64'(wave_of(8'h5A)));

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 9) < 8) d[4] = 1'b1;
      bus.csr_wr_en   = ($urandom_range(0, 19) == 0);
      bus.csr_wr_data = d;
      bus.dr_wr_en    = ($urandom_range(0, 5) == 0);
      bus.dr_wr_data  = 8'($urandom);
      reset           = ($urandom_range(0, 399) == 0);
      tick();
    end
    bus.csr_wr_en = 1'b0; bus.dr_wr_en = 1'b0; reset = 1'b0;
    repeat (FRAME + 5) tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
